// File: rtl/traffic_countdown.sv
// Per-direction seconds countdown reloaded on each LED phase change, shown on a
// 6-digit multiplexed active-low 7-segment display (north digits 0-2, west 3-5).
module traffic_countdown #(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned SCAN_DIV = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       north_red_led,
  input  logic       north_green_led,
  input  logic       north_yellow_led,
  input  logic       west_red_led,
  input  logic       west_green_led,
  input  logic       west_yellow_led,
  input  logic [9:0] north_red_time,
  input  logic [9:0] north_green_time,
  input  logic [9:0] north_yellow_time,
  input  logic [9:0] west_red_time,
  input  logic [9:0] west_green_time,
  input  logic [9:0] west_yellow_time,
  output logic [9:0] north_remain,
  output logic [9:0] west_remain,
  output logic [1:0] fault,
  output logic [7:0] seg,
  output logic [5:0] dig_sel
);

  localparam int unsigned PreW  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PreW-1:0]  PreMax  = PreW'(CLK_HZ - 1);
  localparam logic [ScanW-1:0] ScanMax = ScanW'(SCAN_DIV - 1);

  function automatic logic [9:0] clamp999(input logic [9:0] v);
    return (v > 10'd999) ? 10'd999 : v;
  endfunction

  // One double-dabble step on {bcd[11:0], bin[9:0]}: add-3 correction, then shift.
  function automatic logic [21:0] dabble(input logic [21:0] s);
    logic [21:0] r;
    r = s;
    for (int i = 0; i < 3; i++) begin
      if (r[10 + 4*i +: 4] >= 4'd5) r[10 + 4*i +: 4] = r[10 + 4*i +: 4] + 4'd3;
    end
    return {r[20:0], 1'b0};
  endfunction

  function automatic logic [7:0] seg7(input logic [3:0] v);
    logic [7:0] e;
    case (v)
      4'd0:    e = 8'hC0;
      4'd1:    e = 8'hF9;
      4'd2:    e = 8'hA4;
      4'd3:    e = 8'hB0;
      4'd4:    e = 8'h99;
      4'd5:    e = 8'h92;
      4'd6:    e = 8'h82;
      4'd7:    e = 8'hF8;
      4'd8:    e = 8'h80;
      4'd9:    e = 8'h90;
      default: e = 8'hFF;
    endcase
    return e;
  endfunction

  // Index 0 = north, 1 = west throughout.
  logic [1:0][2:0] led;
  logic [1:0][9:0] red_t, grn_t, yel_t;

  assign led   = {{west_red_led, west_green_led, west_yellow_led},
                  {north_red_led, north_green_led, north_yellow_led}};
  assign red_t = {west_red_time, north_red_time};
  assign grn_t = {west_green_time, north_green_time};
  assign yel_t = {west_yellow_time, north_yellow_time};

  logic [PreW-1:0] pre_q, pre_d;
  logic            tick;
  logic [1:0][2:0] prev_q;
  logic [1:0][9:0] remain_q, remain_d;
  logic [1:0]      fault_q, fault_d;

  always_comb begin
    tick     = (pre_q == PreMax);
    pre_d    = tick ? '0 : pre_q + PreW'(1);
    remain_d = remain_q;
    fault_d  = fault_q;
    for (int d = 0; d < 2; d++) begin
      if (led[d] != prev_q[d]) begin
        fault_d[d] = 1'b0;
        case (led[d])
          3'b100:  remain_d[d] = red_t[d];
          3'b010:  remain_d[d] = grn_t[d];
          3'b001:  remain_d[d] = yel_t[d];
          default: begin
            remain_d[d] = '0;
            fault_d[d]  = 1'b1;
          end
        endcase
      end else if (tick && (remain_q[d] != '0)) begin
        remain_d[d] = remain_q[d] - 10'd1;
      end
    end
  end

  // Shared converter: step 0 samples the clamped remain, steps 1..10 dabble.
  // A stale input restarts the slot once, so a fresh value shows within two
  // slots without letting a fast-changing direction starve the other one.
  logic             dir_q, dir_d;
  logic [3:0]       step_q, step_d;
  logic             retried_q, retried_d;
  logic [9:0]       bin_q, bin_d, cur_in;
  logic [21:0]      sr_q, sr_d, sr_next;
  logic [1:0][11:0] bcd_q, bcd_d;
  logic [1:0]       vld_q, vld_d;

  always_comb begin
    cur_in    = clamp999(remain_q[dir_q]);
    sr_next   = dabble(sr_q);
    dir_d     = dir_q;
    step_d    = step_q;
    retried_d = retried_q;
    bin_d     = bin_q;
    sr_d      = sr_q;
    bcd_d     = bcd_q;
    vld_d     = vld_q;
    if (step_q == 4'd0) begin
      bin_d  = cur_in;
      sr_d   = {12'd0, cur_in};
      step_d = 4'd1;
    end else if ((cur_in != bin_q) && !retried_q) begin
      step_d    = 4'd0;
      retried_d = 1'b1;
    end else begin
      sr_d = sr_next;
      if (step_q == 4'd10) begin
        bcd_d[dir_q] = sr_next[21:10];
        vld_d[dir_q] = 1'b1;
        dir_d        = ~dir_q;
        step_d       = 4'd0;
        retried_d    = 1'b0;
      end else begin
        step_d = step_q + 4'd1;
      end
    end
  end

  logic [ScanW-1:0] scan_q, scan_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       seg_q, seg_d;
  logic [5:0]       dig_sel_q, dig_sel_d;
  logic             ddir;
  logic [1:0]       dpos;
  logic [3:0]       hun, ten, uni;

  // Segment pattern is built for the index after this edge so seg and dig_sel move together.
  always_comb begin
    scan_d = scan_q + ScanW'(1);
    idx_d  = idx_q;
    if (scan_q == ScanMax) begin
      scan_d = '0;
      idx_d  = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end
    ddir            = (idx_d >= 3'd3);
    dpos            = ddir ? 2'(idx_d - 3'd3) : idx_d[1:0];
    {hun, ten, uni} = bcd_q[ddir];
    seg_d           = 8'hFF;
    if (fault_q[ddir]) begin
      seg_d = 8'hBF;
    end else if (vld_q[ddir]) begin
      case (dpos)
        2'd0:    if (hun != 4'd0) seg_d = seg7(hun);
        2'd1:    if ((hun != 4'd0) || (ten != 4'd0)) seg_d = seg7(ten);
        default: seg_d = seg7(uni);
      endcase
    end
    dig_sel_d = ~(6'b000001 << idx_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q     <= '0;
      prev_q    <= '0;
      remain_q  <= '0;
      fault_q   <= '0;
      dir_q     <= 1'b0;
      step_q    <= '0;
      retried_q <= 1'b0;
      bin_q     <= '0;
      sr_q      <= '0;
      bcd_q     <= '0;
      vld_q     <= '0;
      scan_q    <= '0;
      idx_q     <= '0;
      seg_q     <= 8'hFF;
      dig_sel_q <= 6'b111110;
    end else begin
      pre_q     <= pre_d;
      prev_q    <= led;
      remain_q  <= remain_d;
      fault_q   <= fault_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
      retried_q <= retried_d;
      bin_q     <= bin_d;
      sr_q      <= sr_d;
      bcd_q     <= bcd_d;
      vld_q     <= vld_d;
      scan_q    <= scan_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      dig_sel_q <= dig_sel_d;
    end
  end

  assign north_remain = remain_q[0];
  assign west_remain  = remain_q[1];
  assign fault        = fault_q;
  assign seg          = seg_q;
  assign dig_sel      = dig_sel_q;

endmodule

// File: tb/tb_traffic_countdown.sv
// Randomized bench for traffic_countdown: a reference model pushes expected outputs
// each edge into a queue; a monitor pops and compares them half a cycle later.
module tb_traffic_countdown;

  localparam int ClkHz     = 10;
  localparam int ScanDiv   = 2;
  // Display is compared only once a direction's shown value has been steady this long.
  localparam int StableWin = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] n_led, w_led;  // {red, green, yellow}
  logic [9:0] n_rt, n_gt, n_yt, w_rt, w_gt, w_yt;
  logic [9:0] north_remain, west_remain;
  logic [1:0] fault;
  logic [7:0] seg;
  logic [5:0] dig_sel;

  always #5 clk = ~clk;

  traffic_countdown #(.CLK_HZ(ClkHz), .SCAN_DIV(ScanDiv)) dut (
    .clk              (clk),
    .rst              (rst),
    .north_red_led    (n_led[2]),
    .north_green_led  (n_led[1]),
    .north_yellow_led (n_led[0]),
    .west_red_led     (w_led[2]),
    .west_green_led   (w_led[1]),
    .west_yellow_led  (w_led[0]),
    .north_red_time   (n_rt),
    .north_green_time (n_gt),
    .north_yellow_time(n_yt),
    .west_red_time    (w_rt),
    .west_green_time  (w_gt),
    .west_yellow_time (w_yt),
    .north_remain     (north_remain),
    .west_remain      (west_remain),
    .fault            (fault),
    .seg              (seg),
    .dig_sel          (dig_sel)
  );

  typedef struct packed {
    logic [9:0] nr;
    logic [9:0] wr;
    logic [1:0] f;
    logic [5:0] ds;
    logic [7:0] sg;
    logic       chk;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int         m_pre, m_scan, m_idx;
  int         m_rem[2];
  bit         m_fault[2];
  logic [2:0] m_prev[2];
  int         m_code[2];
  int         m_stable[2];

  function automatic logic [7:0] enc(input int v);
    logic [7:0] tbl[10];
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    return tbl[v];
  endfunction

  function automatic int dur(input int d, input logic [2:0] l);
    if (l == 3'b100) return (d == 0) ? int'(n_rt) : int'(w_rt);
    if (l == 3'b010) return (d == 0) ? int'(n_gt) : int'(w_gt);
    return (d == 0) ? int'(n_yt) : int'(w_yt);
  endfunction

  always @(posedge clk) begin
    exp_t       e;
    logic [2:0] cur[2];
    int         code, dir, pos, h, t, u;
    bit         tk;
    cur[0] = n_led;
    cur[1] = w_led;
    if (rst) begin
      m_pre  = 0;
      m_scan = 0;
      m_idx  = 0;
      for (int d = 0; d < 2; d++) begin
        m_rem[d]    = 0;
        m_fault[d]  = 0;
        m_prev[d]   = 3'b000;
        m_code[d]   = 0;
        m_stable[d] = 0;
      end
    end else begin
      tk    = (m_pre == ClkHz - 1);
      m_pre = tk ? 0 : m_pre + 1;
      for (int d = 0; d < 2; d++) begin
        if (cur[d] != m_prev[d]) begin
          if ($countones(cur[d]) == 1) begin
            m_rem[d]   = dur(d, cur[d]);
            m_fault[d] = 0;
          end else begin
            m_rem[d]   = 0;
            m_fault[d] = 1;
          end
        end else if (tk && m_rem[d] > 0) begin
          m_rem[d] = m_rem[d] - 1;
        end
        m_prev[d] = cur[d];
        code = m_fault[d] ? -1 : ((m_rem[d] > 999) ? 999 : m_rem[d]);
        if (code == m_code[d]) m_stable[d] = m_stable[d] + 1;
        else begin
          m_code[d]   = code;
          m_stable[d] = 0;
        end
      end
      m_scan = m_scan + 1;
      if (m_scan == ScanDiv) begin
        m_scan = 0;
        m_idx  = (m_idx + 1) % 6;
      end
    end
    e.nr = 10'(m_rem[0]);
    e.wr = 10'(m_rem[1]);
    e.f  = {m_fault[1], m_fault[0]};
    e.ds = ~(6'b000001 << m_idx);
    dir  = m_idx / 3;
    pos  = m_idx % 3;
    e.sg = 8'hFF;
    if (rst) begin
      e.chk = 1'b1;
    end else begin
      e.chk = (m_stable[dir] >= StableWin);
      if (m_fault[dir]) e.sg = 8'hBF;
      else begin
        h = m_code[dir] / 100;
        t = (m_code[dir] / 10) % 10;
        u = m_code[dir] % 10;
        if (pos == 0) e.sg = (h != 0) ? enc(h) : 8'hFF;
        else if (pos == 1) e.sg = (h != 0 || t != 0) ? enc(t) : 8'hFF;
        else e.sg = enc(u);
      end
    end
    exp_q.push_back(e);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("north_remain", 32'(north_remain), 32'(e.nr));
      check("west_remain", 32'(west_remain), 32'(e.wr));
      check("fault", 32'(fault), 32'(e.f));
      check("dig_sel", 32'(dig_sel), 32'(e.ds));
      if (e.chk) check("seg", 32'(seg), 32'(e.sg));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [2:0] pick_led();
    logic [2:0] oh[3];
    oh = '{3'b100, 3'b010, 3'b001};
    if ($urandom_range(0, 3) != 0) return oh[$urandom_range(0, 2)];
    return 3'($urandom_range(0, 7));
  endfunction

  function automatic logic [9:0] pick_time();
    if ($urandom_range(0, 5) == 0) return 10'($urandom_range(990, 1023));
    return 10'($urandom_range(0, 12));
  endfunction

  initial begin
    int r;
    rst   = 1'b1;
    n_led = 3'b000;
    w_led = 3'b000;
    n_rt  = '0; n_gt = '0; n_yt = '0;
    w_rt  = '0; w_gt = '0; w_yt = '0;
    @(negedge clk);
    cyc(5);
    rst = 1'b0;
    cyc(3);
    // Countdown from 5, then saturation at 0.
    n_gt  = 10'd5;
    n_led = 3'b010;
    cyc(85);
    // West load coinciding with a tick must win over the decrement.
    w_rt = 10'd7;
    for (int i = 0; i < 20 && m_pre != ClkHz - 1; i++) cyc(1);
    w_led = 3'b100;
    cyc(25);
    // Illegal north triple, then recovery.
    n_led = 3'b110;
    cyc(60);
    n_yt  = 10'd3;
    n_led = 3'b001;
    cyc(60);
    // Clamp to 999, mid-phase time change ignored, single-digit north.
    w_gt  = 10'd1023;
    w_led = 3'b010;
    n_rt  = 10'd0;
    n_led = 3'b100;
    cyc(1);
    n_yt  = 10'd7;
    n_led = 3'b001;
    cyc(10);
    w_gt  = 10'd4;
    cyc(80);
    // Reset pulse mid-countdown, then reload on the first cycle after release.
    n_gt  = 10'd3;
    n_led = 3'b010;
    cyc(2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(60);
    for (int it = 0; it < 250; it++) begin
      r = int'($urandom_range(0, 9));
      n_rt = pick_time(); n_gt = pick_time(); n_yt = pick_time();
      w_rt = pick_time(); w_gt = pick_time(); w_yt = pick_time();
      if (r < 4) n_led = pick_led();
      else if (r < 8) w_led = pick_led();
      else if (r == 8) begin
        n_led = pick_led();
        w_led = pick_led();
      end else begin
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
      end
      if ($urandom_range(0, 4) == 0) cyc(120);
      else cyc(int'($urandom_range(1, 40)));
    end
    cyc(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
